// File: rtl/idli_sqi_ctrl_m.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : idli_sqi_ctrl_m
// Purpose  : SQI transaction sequencer for a 23LC1024-style serial SRAM that
//            is already in SQI mode. It frames each core request as CS low,
//            an 8-bit command, a 24-bit byte address, a dummy byte (reads
//            only) and a burst of 16-bit words on the 4-bit SIO bus.
// Ports    : i_sqi_gck/i_sqi_rst  - SQI clock, synchronous active-high reset
//            i_req_*/o_req_rdy    - request handshake (accepted only in IDLE)
//            o_sqi_cs_n/o_sqi_sio/o_sqi_sio_oe/i_sqi_sio - SRAM pin interface
//            o_buf_wr_en/o_rd_data/o_rd_vld - read nibble stream to rotate buf
//            i_wr_data/o_wr_rdy   - write nibble stream (no backpressure)
//            o_busy               - transaction in progress
// Revision : 1.0 - initial release
// ============================================================================
module idli_sqi_ctrl_m #(
    parameter int BURST_W = 4
) (
    input  logic               i_sqi_gck,
    input  logic               i_sqi_rst,
    input  logic               i_req_vld,
    output logic               o_req_rdy,
    input  logic               i_req_wr,
    input  logic [15:0]        i_req_addr,
    input  logic [BURST_W-1:0] i_req_len,
    output logic               o_sqi_cs_n,
    output logic [3:0]         o_sqi_sio,
    output logic               o_sqi_sio_oe,
    input  logic [3:0]         i_sqi_sio,
    output logic               o_buf_wr_en,
    output logic [3:0]         o_rd_data,
    output logic               o_rd_vld,
    input  logic [3:0]         i_wr_data,
    output logic               o_wr_rdy,
    output logic               o_busy
);

    // Counter must hold 4*2**BURST_W - 1 (the longest data phase).
    localparam int CNT_W = BURST_W + 2;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_CMD   = 3'd1;
    localparam logic [2:0] c_ST_ADDR  = 3'd2;
    localparam logic [2:0] c_ST_DUMMY = 3'd3;
    localparam logic [2:0] c_ST_DATA  = 3'd4;
    localparam logic [2:0] c_ST_END   = 3'd5;

    // Phase lengths minus one, loaded on phase entry.
    localparam logic [CNT_W-1:0] c_CNT_CMD   = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_CNT_ADDR  = CNT_W'(5);
    localparam logic [CNT_W-1:0] c_CNT_DUMMY = CNT_W'(1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_wr;
    logic [15:0]        r_addr;
    logic [BURST_W-1:0] r_len;
    logic [3:0]         r_rd_data;
    logic               r_rd_vld;
    logic               w_accept;
    logic               w_cnt_zero;
    logic [23:0]        w_byte_addr;
    logic [3:0]         w_addr_nib;

    assign w_accept    = i_req_vld && (r_state == c_ST_IDLE);
    assign w_cnt_zero  = (r_cnt == '0);
    assign w_byte_addr = {7'b0, r_addr, 1'b0};

    // ------------------------------------------------------------------
    // State and nibble counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge i_sqi_gck) begin
        if (i_sqi_rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Request fields are captured only on acceptance so that requests
    // presented during a transfer cannot disturb it.
    always_ff @(posedge i_sqi_gck) begin
        if (i_sqi_rst) begin
            r_wr   <= 1'b0;
            r_addr <= '0;
            r_len  <= '0;
        end else if (w_accept) begin
            r_wr   <= i_req_wr;
            r_addr <= i_req_addr;
            r_len  <= i_req_len;
        end
    end

    // Read path: pins sampled every cycle; valid trails the buffer enable.
    always_ff @(posedge i_sqi_gck) begin
        if (i_sqi_rst) begin
            r_rd_data <= 4'h0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_rd_data <= i_sqi_sio;
            r_rd_vld  <= o_buf_wr_en;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt - CNT_W'(1);
        case (r_state)
            c_ST_IDLE: begin
                w_cnt_nxt = r_cnt;
                if (w_accept) begin
                    w_state_nxt = c_ST_CMD;
                    w_cnt_nxt   = c_CNT_CMD;
                end
            end
            c_ST_CMD: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_ST_ADDR;
                    w_cnt_nxt   = c_CNT_ADDR;
                end
            end
            c_ST_ADDR: begin
                if (w_cnt_zero) begin
                    if (r_wr) begin
                        w_state_nxt = c_ST_DATA;
                        w_cnt_nxt   = {r_len, 2'b11};
                    end else begin
                        w_state_nxt = c_ST_DUMMY;
                        w_cnt_nxt   = c_CNT_DUMMY;
                    end
                end
            end
            c_ST_DUMMY: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_ST_DATA;
                    // 4*(len+1)-1 nibbles, fits CNT_W without overflow
                    w_cnt_nxt   = {r_len, 2'b11};
                end
            end
            c_ST_DATA: begin
                if (w_cnt_zero) begin
                    w_state_nxt = c_ST_END;
                end
            end
            c_ST_END: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = r_cnt;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Address nibble select: the counter runs 5..0 so it indexes MSB first.
    always_comb begin
        w_addr_nib = 4'h0;
        case (r_cnt[2:0])
            3'd5:    w_addr_nib = w_byte_addr[23:20];
            3'd4:    w_addr_nib = w_byte_addr[19:16];
            3'd3:    w_addr_nib = w_byte_addr[15:12];
            3'd2:    w_addr_nib = w_byte_addr[11:8];
            3'd1:    w_addr_nib = w_byte_addr[7:4];
            3'd0:    w_addr_nib = w_byte_addr[3:0];
            default: w_addr_nib = 4'h0;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        o_sqi_cs_n   = 1'b1;
        o_sqi_sio_oe = 1'b0;
        o_sqi_sio    = 4'h0;
        o_buf_wr_en  = 1'b0;
        o_wr_rdy     = 1'b0;
        case (r_state)
            c_ST_CMD: begin
                o_sqi_cs_n   = 1'b0;
                o_sqi_sio_oe = 1'b1;
                // 0x02 = WRITE, 0x03 = READ; high nibble is always zero
                o_sqi_sio    = (r_cnt == c_CNT_CMD) ? 4'h0 : {3'b001, ~r_wr};
            end
            c_ST_ADDR: begin
                o_sqi_cs_n   = 1'b0;
                o_sqi_sio_oe = 1'b1;
                o_sqi_sio    = w_addr_nib;
            end
            c_ST_DUMMY: begin
                o_sqi_cs_n = 1'b0;
            end
            c_ST_DATA: begin
                o_sqi_cs_n   = 1'b0;
                o_sqi_sio_oe = r_wr;
                o_sqi_sio    = r_wr ? i_wr_data : 4'h0;
                o_buf_wr_en  = ~r_wr;
                o_wr_rdy     = r_wr;
            end
            default: begin
            end
        endcase
    end

    assign o_busy    = (r_state != c_ST_IDLE);
    assign o_req_rdy = (r_state == c_ST_IDLE);
    assign o_rd_data = r_rd_data;
    assign o_rd_vld  = r_rd_vld;

endmodule
`default_nettype wire

// File: tb/tb_idli_sqi_ctrl_m.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_idli_sqi_ctrl_m
// Purpose  : Self-checking bench for idli_sqi_ctrl_m. A transaction-level
//            model expands each accepted request into the per-cycle pin
//            frames it must produce; a compare process checks every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_idli_sqi_ctrl_m;

    localparam int BURST_W = 4;

    logic               clk = 1'b0;
    logic               rst;
    logic               req_vld;
    logic               req_rdy;
    logic               req_wr;
    logic [15:0]        req_addr;
    logic [BURST_W-1:0] req_len;
    logic               cs_n;
    logic [3:0]         sio_out;
    logic               sio_oe;
    logic [3:0]         sio_in;
    logic               buf_wr_en;
    logic [3:0]         rd_data;
    logic               rd_vld;
    logic [3:0]         wr_data;
    logic               wr_rdy;
    logic               busy;

    always #5 clk = ~clk;

    idli_sqi_ctrl_m #(.BURST_W(BURST_W)) dut (
        .i_sqi_gck    (clk),
        .i_sqi_rst    (rst),
        .i_req_vld    (req_vld),
        .o_req_rdy    (req_rdy),
        .i_req_wr     (req_wr),
        .i_req_addr   (req_addr),
        .i_req_len    (req_len),
        .o_sqi_cs_n   (cs_n),
        .o_sqi_sio    (sio_out),
        .o_sqi_sio_oe (sio_oe),
        .i_sqi_sio    (sio_in),
        .o_buf_wr_en  (buf_wr_en),
        .o_rd_data    (rd_data),
        .o_rd_vld     (rd_vld),
        .i_wr_data    (wr_data),
        .o_wr_rdy     (wr_rdy),
        .o_busy       (busy)
    );

    // One expected bus cycle
    typedef struct {
        bit         idle;
        bit         cs_n;
        bit         oe;
        logic [3:0] sio;
        bit         bwe;
        bit         wrr;
        logic [3:0] sio_in;
        logic [3:0] wr_nib;
    } frame_t;

    frame_t      exp_q[$];
    logic [15:0] wr_words[$];
    logic [15:0] sram[int];

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;
    int cyc = 0;

    // Observation logs used by the hand-computed checks
    logic [3:0] pin_log[$];
    logic [3:0] rd_log[$];
    int rd_cnt, cs_low_cnt, cs_hi_run, last_hi_gap, last_bwe_cyc, acc_gap;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare a nibble log against n nibbles of a packed literal, MSB first
    task automatic chk_log(input string name, input logic [3:0] a[$], input logic [63:0] e, input int n);
        logic [63:0] act;
        act = '0;
        chk({name, "_len"}, 64'(a.size()), 64'(n));
        foreach (a[i]) act = {act[59:0], a[i]};
        chk(name, act, e);
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        if (sram.exists(int'(a))) return sram[int'(a)];
        return a ^ 16'h5A5A;
    endfunction

    function automatic frame_t idle_frame();
        frame_t f;
        f.idle = 1'b1; f.cs_n = 1'b1; f.oe = 1'b0; f.sio = 4'h0;
        f.bwe = 1'b0; f.wrr = 1'b0;
        f.sio_in = 4'($urandom); f.wr_nib = 4'($urandom);
        return f;
    endfunction

    // Expand an accepted request into the frames of the following cycles
    task automatic build_txn(input bit wr, input logic [15:0] addr, input logic [BURST_W-1:0] len);
        frame_t f;
        logic [23:0] ba;
        logic [15:0] w;
        ba = {7'b0, addr, 1'b0};
        f = idle_frame();
        f.idle = 1'b0; f.cs_n = 1'b0; f.oe = 1'b1;
        f.sio = 4'h0;                   exp_q.push_back(f);
        f.sio = wr ? 4'h2 : 4'h3;       exp_q.push_back(f);
        for (int i = 5; i >= 0; i--) begin
            f.sio = ba[i*4 +: 4];
            f.sio_in = 4'($urandom);
            exp_q.push_back(f);
        end
        if (!wr) begin
            f.oe = 1'b0; f.sio = 4'h0;
            for (int i = 0; i < 2; i++) begin
                f.sio_in = 4'($urandom);
                exp_q.push_back(f);
            end
        end
        for (int k = 0; k <= int'(len); k++) begin
            if (wr) w = (wr_words.size() > 0) ? wr_words.pop_front() : 16'h0000;
            else    w = mem_word(addr + 16'(k));
            for (int j = 3; j >= 0; j--) begin
                f.oe = wr; f.wrr = wr; f.bwe = !wr;
                f.sio    = wr ? w[j*4 +: 4] : 4'h0;
                f.sio_in = wr ? 4'($urandom) : w[j*4 +: 4];
                f.wr_nib = wr ? w[j*4 +: 4] : 4'($urandom);
                exp_q.push_back(f);
            end
        end
        f = idle_frame();
        f.idle = 1'b0;                  // END: CS high but still busy
        exp_q.push_back(f);
    endtask

    // Model, pin driver and per-cycle compare
    initial begin
        frame_t f;
        logic       exp_vld;
        logic [3:0] exp_data;
        exp_vld = 1'b0; exp_data = 4'h0;
        forever begin
            @(negedge clk);
            cyc++;
            f = (exp_q.size() > 0) ? exp_q[0] : idle_frame();
            sio_in  = f.sio_in;
            wr_data = f.wr_nib;
            #1;
            if (check_en) begin
                chk("cs_n",      64'(cs_n),      64'(f.cs_n));
                chk("sio_oe",    64'(sio_oe),    64'(f.oe));
                if (f.oe) chk("sio", 64'(sio_out), 64'(f.sio));
                chk("buf_wr_en", 64'(buf_wr_en), 64'(f.bwe));
                chk("wr_rdy",    64'(wr_rdy),    64'(f.wrr));
                chk("busy",      64'(busy),      64'(!f.idle));
                chk("req_rdy",   64'(req_rdy),   64'(f.idle));
                chk("rd_vld",    64'(rd_vld),    64'(exp_vld));
                chk("rd_data",   64'(rd_data),   64'(exp_data));
                if (sio_oe) pin_log.push_back(sio_out);
                if (rd_vld) begin rd_log.push_back(rd_data); rd_cnt++; end
                if (!cs_n) cs_low_cnt++;
                if (cs_n) cs_hi_run++;
                else begin
                    if (cs_hi_run > 0) last_hi_gap = cs_hi_run;
                    cs_hi_run = 0;
                end
                if (buf_wr_en) last_bwe_cyc = cyc;
                if (req_rdy && req_vld) acc_gap = cyc - last_bwe_cyc;
            end
            if (rst) begin
                exp_q.delete();
                exp_vld = 1'b0; exp_data = 4'h0;
            end else begin
                exp_vld = f.bwe; exp_data = f.sio_in;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
                else if (req_vld) build_txn(req_wr, req_addr, req_len);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic clear_logs();
        pin_log.delete(); rd_log.delete();
        rd_cnt = 0; cs_low_cnt = 0;
    endtask

    task automatic req(input bit wr, input logic [15:0] addr, input logic [BURST_W-1:0] len);
        req_vld = 1'b1; req_wr = wr; req_addr = addr; req_len = len;
        step(1);
        req_vld = 1'b0;
    endtask

    initial begin
        rst = 1'b1; req_vld = 1'b0; req_wr = 1'b0; req_addr = '0; req_len = '0;
        sio_in = 4'h0; wr_data = 4'h0;
        cs_hi_run = 0; last_hi_gap = 0; last_bwe_cyc = 0; acc_gap = 0;
        clear_logs();
        step(3);
        check_en = 1'b1;
        chk("rst_cs_n",    64'(cs_n),      64'd1);
        chk("rst_oe",      64'(sio_oe),    64'd0);
        chk("rst_sio",     64'(sio_out),   64'd0);
        chk("rst_bwe",     64'(buf_wr_en), 64'd0);
        chk("rst_rd_vld",  64'(rd_vld),    64'd0);
        chk("rst_rd_data", 64'(rd_data),   64'd0);
        chk("rst_wr_rdy",  64'(wr_rdy),    64'd0);
        chk("rst_busy",    64'(busy),      64'd0);
        chk("rst_req_rdy", 64'(req_rdy),   64'd1);
        rst = 1'b0;
        step(1);

        // Single-word read of 0xBEEF from word 0x1234
        clear_logs();
        sram[int'(16'h1234)] = 16'hBEEF;
        req(1'b0, 16'h1234, 4'd0);
        step(20);
        chk_log("rd1_pins", pin_log, 64'h0300_2468, 8);
        chk_log("rd1_data", rd_log, 64'hBEEF, 4);
        chk("rd1_cs_low", 64'(cs_low_cnt), 64'd14);

        // Two-word write to the top word address
        clear_logs();
        wr_words.push_back(16'hA5C3);
        wr_words.push_back(16'h0001);
        req(1'b1, 16'hFFFF, 4'd1);
        step(22);
        chk_log("wr1_pins", pin_log, 64'h0201_FFFE_A5C3_0001, 16);
        chk("wr1_cs_low", 64'(cs_low_cnt), 64'd16);

        // Longest burst: counter must not wrap
        clear_logs();
        req(1'b0, 16'h0100, 4'd15);
        step(85);
        chk("rd16_vld_cnt", 64'(rd_cnt), 64'd64);
        chk("rd16_cs_low",  64'(cs_low_cnt), 64'd74);

        // Request held valid across two back-to-back reads
        clear_logs();
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 16'h0010; req_len = 4'd0;
        step(20);
        req_vld = 1'b0;
        step(20);
        chk("b2b_acc_gap", 64'(acc_gap), 64'd2);
        chk("b2b_cs_hi",   64'(last_hi_gap), 64'd2);
        chk("b2b_vld_cnt", 64'(rd_cnt), 64'd8);

        // Reset while the read address is being sent
        clear_logs();
        req(1'b0, 16'h4321, 4'd2);
        step(2);
        rst = 1'b1;
        step(1);
        chk("mid_rst_cs_n",    64'(cs_n),    64'd1);
        chk("mid_rst_oe",      64'(sio_oe),  64'd0);
        chk("mid_rst_busy",    64'(busy),    64'd0);
        chk("mid_rst_req_rdy", 64'(req_rdy), 64'd1);
        rst = 1'b0;
        step(30);
        chk("mid_rst_vld_cnt", 64'(rd_cnt), 64'd0);

        // New request raised during a write's data phase must be ignored
        clear_logs();
        wr_words.push_back(16'h1357);
        wr_words.push_back(16'h9BDF);
        req(1'b1, 16'h2222, 4'd1);
        step(9);
        req_vld = 1'b1; req_wr = 1'b0; req_addr = 16'h3333; req_len = 4'd3;
        chk("ign_req_rdy0", 64'(req_rdy), 64'd0);
        step(1);
        chk("ign_req_rdy1", 64'(req_rdy), 64'd0);
        req_vld = 1'b0;
        step(15);
        chk_log("ign_pins", pin_log, 64'h0200_4444_1357_9BDF, 16);
        chk("ign_cs_low", 64'(cs_low_cnt), 64'd16);
        chk("ign_vld_cnt", 64'(rd_cnt), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
